// File: rtl/npc_exec_core_if.sv
// Execute-core bus: register-file ports, ALU operands/result and funct3 decode.
// The master side is the NPC decode logic; the slave side is npc_exec_core.
interface npc_exec_core_if #(
    parameter int XLEN      = 32,
    parameter int NREG_LOG2 = 5
);
    logic                 wen;
    logic [NREG_LOG2-1:0] waddr;
    logic [XLEN-1:0]      wdata;
    logic [NREG_LOG2-1:0] raddr1;
    logic [XLEN-1:0]      rdata1;
    logic [NREG_LOG2-1:0] raddr2;
    logic [XLEN-1:0]      rdata2;
    logic [XLEN-1:0]      alu_src1;
    logic [XLEN-1:0]      alu_src2;
    logic [9:0]           alu_op;
    logic [XLEN-1:0]      alu_result;
    logic [2:0]           funct3;
    logic [7:0]           funct3_d;

    modport master (
        output wen, waddr, wdata, raddr1, raddr2,
        output alu_src1, alu_src2, alu_op, funct3,
        input  rdata1, rdata2, alu_result, funct3_d
    );

    modport slave (
        input  wen, waddr, wdata, raddr1, raddr2,
        input  alu_src1, alu_src2, alu_op, funct3,
        output rdata1, rdata2, alu_result, funct3_d
    );
endinterface

// File: rtl/npc_exec_core.sv
// RV32 NPC execute core: 2R1W register file with hardwired x0, one-hot ALU,
// and a 3-to-8 one-hot funct3 decoder.
module npc_exec_core #(
    parameter int XLEN      = 32,
    parameter int NREG_LOG2 = 5
) (
    input  logic              clk,
    input  logic              reset,
    npc_exec_core_if.slave    bus
);
    localparam int NREGS = 2 ** NREG_LOG2;
    localparam int SHW   = $clog2(XLEN);

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_AND,
        OP_OR,  OP_XOR, OP_SLL, OP_SRL,  OP_SRA
    } alu_op_e;

    // ------------------------------------------------------------ register file
    logic [XLEN-1:0] regs [NREGS];

    // NOTE: the whole array is reset so reads never see X, which keeps it in
    // flops rather than a RAM macro; state updates use non-blocking (<=).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (bus.wen && (bus.waddr != '0)) begin
            regs[bus.waddr] <= bus.wdata;
        end
    end

    // x0 is forced to zero at the read mux; no write-to-read bypass.
    assign bus.rdata1 = (bus.raddr1 == '0) ? '0 : regs[bus.raddr1];
    assign bus.rdata2 = (bus.raddr2 == '0) ? '0 : regs[bus.raddr2];

    // -------------------------------------------------------------------- ALU
    logic [XLEN-1:0] a, b, result;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] res [10];

    assign a     = bus.alu_src1;
    assign b     = bus.alu_src2;
    assign shamt = b[SHW-1:0];

    always_comb begin
        res[OP_ADD]  = a + b;
        res[OP_SUB]  = a - b;
        res[OP_SLT]  = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
        res[OP_SLTU] = {{(XLEN-1){1'b0}}, (a < b)};
        res[OP_AND]  = a & b;
        res[OP_OR]   = a | b;
        res[OP_XOR]  = a ^ b;
        res[OP_SLL]  = a << shamt;
        res[OP_SRL]  = a >> shamt;
        res[OP_SRA]  = XLEN'($signed(a) >>> shamt);

        // AND-OR select: no op gives 0, several ops give the OR of their results.
        result = '0;
        for (int i = 0; i < 10; i++) begin
            if (bus.alu_op[i]) result = result | res[i];
        end
    end

    assign bus.alu_result = result;

    // ---------------------------------------------------------------- decoder
    always_comb begin
        bus.funct3_d              = '0;
        bus.funct3_d[bus.funct3]  = 1'b1;
    end
endmodule

// File: tb/tb_npc_exec_core.sv
// Self-checking bench for npc_exec_core: directed ALU/decoder vectors, register
// file reset/timing sequences, then randomized traffic against a reference model.
module tb_npc_exec_core;
    logic clk = 1'b0;
    logic reset;

    npc_exec_core_if bus ();

    npc_exec_core dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_regs [32];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Reference ALU built from arithmetic on wide integers rather than bit operators.
    function automatic logic [31:0] ref_one(input int op, input logic [31:0] a, input logic [31:0] b);
        longint ua = longint'({32'b0, a});
        longint ub = longint'({32'b0, b});
        longint sa = longint'($signed(a));
        int     sh = int'(b % 32);
        longint d  = 64'sd1 <<< sh;
        case (op)
            0: return 32'(ua + ub);
            1: return 32'(ua - ub);
            2: return (sa < longint'($signed(b))) ? 32'd1 : 32'd0;
            3: return (ua < ub) ? 32'd1 : 32'd0;
            4: return a & b;
            5: return a | b;
            6: return a ^ b;
            7: return 32'(ua * d);
            8: return 32'(ua / d);
            default: begin
                if (sa >= 0) return 32'(sa / d);
                return 32'(-((-sa + d - 1) / d));
            end
        endcase
    endfunction

    function automatic logic [31:0] ref_alu(input logic [9:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r = 32'd0;
        for (int i = 0; i < 10; i++) if (op[i]) r = r | ref_one(i, a, b);
        return r;
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] addr);
        return (addr == 5'd0) ? 32'd0 : model_regs[addr];
    endfunction

    typedef struct {
        string       name;
        logic [9:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expected;
    } alu_vec_t;

    alu_vec_t   vecs [14];
    logic [7:0] dec_exp [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    initial begin
        vecs[0]  = '{"add_wrap",   10'h001, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
        vecs[1]  = '{"add_sign",   10'h001, 32'h80000000, 32'h00000010, 32'h80000010};
        vecs[2]  = '{"sub_wrap",   10'h002, 32'h00000000, 32'h00000001, 32'hFFFFFFFF};
        vecs[3]  = '{"slt_neg",    10'h004, 32'hFFFFFFFF, 32'h00000001, 32'h00000001};
        vecs[4]  = '{"sltu_big",   10'h008, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
        vecs[5]  = '{"sra_shamt",  10'h200, 32'h80000000, 32'h00000021, 32'hC0000000};
        vecs[6]  = '{"srl_shamt",  10'h100, 32'h80000000, 32'h00000021, 32'h40000000};
        vecs[7]  = '{"sll_31",     10'h080, 32'h00000001, 32'h0000001F, 32'h80000000};
        vecs[8]  = '{"and",        10'h010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000};
        vecs[9]  = '{"or",         10'h020, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0};
        vecs[10] = '{"xor",        10'h040, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0};
        vecs[11] = '{"op_none",    10'h000, 32'h12345678, 32'h9ABCDEF0, 32'h00000000};
        vecs[12] = '{"op_and_or",  10'h030, 32'h0000000C, 32'h0000000A, 32'h0000000E};
        vecs[13] = '{"slt_equal",  10'h004, 32'h80000000, 32'h80000000, 32'h00000000};

        reset        = 1'b1;
        bus.wen      = 1'b0;
        bus.waddr    = '0;
        bus.wdata    = '0;
        bus.raddr1   = '0;
        bus.raddr2   = '0;
        bus.alu_src1 = '0;
        bus.alu_src2 = '0;
        bus.alu_op   = '0;
        bus.funct3   = '0;
        for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Every register reads zero out of reset.
        for (int r = 0; r < 32; r++) begin
            bus.raddr1 = 5'(r);
            bus.raddr2 = 5'(31 - r);
            #1;
            check($sformatf("reset_rd1_x%0d", r), bus.rdata1, 32'd0);
            check($sformatf("reset_rd2_x%0d", 31 - r), bus.rdata2, 32'd0);
        end

        // Directed ALU vectors.
        foreach (vecs[i]) begin
            bus.alu_op   = vecs[i].op;
            bus.alu_src1 = vecs[i].a;
            bus.alu_src2 = vecs[i].b;
            #1;
            check(vecs[i].name, bus.alu_result, vecs[i].expected);
        end

        // Decoder sweep.
        for (int k = 0; k < 8; k++) begin
            bus.funct3 = 3'(k);
            #1;
            check($sformatf("dec_%0d", k), {24'b0, bus.funct3_d}, {24'b0, dec_exp[k]});
        end

        // Asynchronous reset mid-cycle clears a written register before any edge.
        @(negedge clk);
        bus.wen = 1'b1; bus.waddr = 5'd5; bus.wdata = 32'h12345678; bus.raddr1 = 5'd5;
        @(posedge clk); #1;
        bus.wen = 1'b0;
        check("x5_written", bus.rdata1, 32'h12345678);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_x5", bus.rdata1, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Writes to x0 are discarded.
        bus.wen = 1'b1; bus.waddr = 5'd0; bus.wdata = 32'hFFFFFFFF; bus.raddr1 = 5'd0;
        @(posedge clk); #1;
        check("x0_write_ignored", bus.rdata1, 32'd0);

        // Write/read timing: old value before the edge, new value after, held with wen=0.
        @(negedge clk);
        bus.wen = 1'b1; bus.waddr = 5'd10; bus.wdata = 32'hDEADBEEF;
        bus.raddr1 = 5'd10; bus.raddr2 = 5'd10;
        #1;
        check("pre_edge_rd1", bus.rdata1, 32'd0);
        check("pre_edge_rd2", bus.rdata2, 32'd0);
        @(posedge clk); #1;
        check("post_edge_rd1", bus.rdata1, 32'hDEADBEEF);
        check("post_edge_rd2", bus.rdata2, 32'hDEADBEEF);
        bus.wen = 1'b0; bus.wdata = 32'h01010101;
        @(posedge clk); #1;
        check("hold_wen0", bus.rdata1, 32'hDEADBEEF);
        model_regs[10] = 32'hDEADBEEF;

        // Randomized traffic against the reference model.
        for (int it = 0; it < 400; it++) begin
            logic [31:0] pick;
            @(negedge clk);
            bus.wen    = ($urandom_range(0, 3) != 0);
            bus.waddr  = 5'($urandom_range(0, 31));
            bus.wdata  = $urandom;
            bus.raddr1 = ($urandom_range(0, 3) == 0) ? bus.waddr : 5'($urandom_range(0, 31));
            bus.raddr2 = 5'($urandom_range(0, 31));
            bus.funct3 = 3'($urandom_range(0, 7));
            pick = $urandom_range(0, 11);
            if (pick < 10)       bus.alu_op = 10'(1) << pick;
            else if (pick == 10) bus.alu_op = 10'($urandom);
            else                 bus.alu_op = '0;
            bus.alu_src1 = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            bus.alu_src2 = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
            #1;
            check($sformatf("rnd%0d_rd1", it), bus.rdata1, ref_read(bus.raddr1));
            check($sformatf("rnd%0d_rd2", it), bus.rdata2, ref_read(bus.raddr2));
            check($sformatf("rnd%0d_alu", it), bus.alu_result, ref_alu(bus.alu_op, bus.alu_src1, bus.alu_src2));
            check($sformatf("rnd%0d_dec", it), {24'b0, bus.funct3_d}, 32'd1 << bus.funct3);
            @(posedge clk);
            if (bus.wen && bus.waddr != 5'd0) model_regs[bus.waddr] = bus.wdata;
            #1;
            check($sformatf("rnd%0d_post_rd1", it), bus.rdata1, ref_read(bus.raddr1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/npc_exec_core.md
Name: npc_exec_core

Overview:
- Execute-stage core of the single-cycle RV32 NPC. Bundles three functions:
  - a 32x32-bit general-purpose register file with two combinational read ports and one synchronous write port;
  - a one-hot-controlled ALU;
  - a 3-to-8 one-hot decoder for funct3.
- The NPC top level drives the register addresses, write-back data, ALU operands, ALU op and funct3 from its decode logic. It consumes rdata1/rdata2, alu_result and funct3_d.

Parameters:
- XLEN, 32, data width of registers, ALU operands and result.
- NREG_LOG2, 5, register address width; 2**NREG_LOG2 registers (32).

Ports:
- clk  input  1  rising-edge clock for register writes.
- reset  input  1  asynchronous, active-high; clears register file.
- wen  input  1  register write enable.
- waddr  input  5  write register index.
- wdata  input  32  write-back data.
- raddr1  input  5  read port 1 index (rs1).
- rdata1  output  32  read port 1 data (src1).
- raddr2  input  5  read port 2 index (rs2).
- rdata2  output  32  read port 2 data (src2).
- alu_src1  input  32  ALU operand A.
- alu_src2  input  32  ALU operand B.
- alu_op  input  10  one-hot ALU operation select.
- alu_result  output  32  ALU result.
- funct3  input  3  instruction funct3 field.
- funct3_d  output  8  one-hot decode of funct3.

Behaviour:
- Register file:
  - x1..x31 are XLEN-bit flops.
  - x0 is hardwired: it always reads 0, and writes to it are discarded.
  - Write: on posedge clk, if wen=1, reset=0 and waddr!=0, then regs[waddr] <= wdata.
  - Read: rdata1 = (raddr1==0) ? 0 : regs[raddr1]; rdata2 likewise for raddr2. Both are purely combinational, so zero latency.
  - No write-to-read bypass. A read of the same index being written returns the old value until the clock edge; the new value is visible immediately after the edge.
  - Reset: while reset=1, all registers are asynchronously forced to 0 and writes are ignored. Asserting reset mid-operation clears state without waiting for a clock. Normal writes resume on the first posedge after deassertion.
- ALU: purely combinational; no clock or reset dependency. All arithmetic is XLEN bits; carries and overflow are discarded (wrap-around).
  - alu_op bit mapping:
    - bit0 ADD: A+B.
    - bit1 SUB: A-B.
    - bit2 SLT: {31'b0, signed(A)<signed(B)}.
    - bit3 SLTU: {31'b0, A<B unsigned}.
    - bit4 AND.
    - bit5 OR.
    - bit6 XOR.
    - bit7 SLL: A << B[4:0].
    - bit8 SRL: logical A >> B[4:0].
    - bit9 SRA: arithmetic A >>> B[4:0].
  - Shifts use only B[4:0]; B[31:5] is ignored.
  - The result is the AND-OR combination of the selected per-op results: alu_result = OR over i of ({32{alu_op[i]}} & res_i).
    - alu_op = 0 gives alu_result = 0.
    - Multiple set bits give the bitwise OR of the selected results. This is legal but not used by the decoder.
- Decoder: funct3_d[k] = (funct3 == k) for k = 0..7. Exactly one bit is set for every input. Purely combinational.
- Outputs after reset:
  - rdata1/rdata2 = 0 for any address.
  - alu_result and funct3_d depend only on their inputs.
- No X-propagation from uninitialised storage: all 31 registers are reset.

Test Plan:
- Reset/x0: assert reset asynchronously mid-cycle after writing x5=0x12345678 -> rdata1 (raddr1=5) reads 0 immediately, before any clock edge. Then wen=1, waddr=0, wdata=0xFFFFFFFF, clock -> raddr1=0 reads 0.
- Write/read timing: wen=1, waddr=10, wdata=0xDEADBEEF, raddr1=raddr2=10 -> before the edge both read the prior value 0; after the posedge both read 0xDEADBEEF. With wen=0 and wdata changed, the value stays 0xDEADBEEF.
- ADD/SUB wrap:
  - alu_op=bit0, A=0xFFFFFFFF, B=1 -> 0x00000000.
  - alu_op=bit0, A=0x80000000, B=0x10 -> 0x80000010.
  - alu_op=bit1, A=0, B=1 -> 0xFFFFFFFF.
- Compare/logic/shift:
  - SLT A=0xFFFFFFFF, B=1 -> 1; SLTU with the same operands -> 0.
  - SRA A=0x80000000, B=0x21 (shamt 1) -> 0xC0000000; SRL with the same operands -> 0x40000000.
  - SLL A=1, B=31 -> 0x80000000.
  - AND/OR/XOR of 0xF0F0F0F0 with 0xFF00FF00 -> 0xF000F000 / 0xFFF0FFF0 / 0x0FF00FF0.
- Op-select edges: alu_op=0 -> 0. alu_op=bit4|bit5 with A=0xC, B=0xA -> (0x8|0xE)=0xE.
- Decoder sweep: funct3 = 0..7 -> funct3_d = 0x01, 0x02, 0x04, 0x08, 0x10, 0x20, 0x40, 0x80; funct3=2 -> 0x04 exactly.
